// File: rtl/jelly_img_sobel_grad_pkg.sv
// Shared constants and types for the Sobel gradient block: pipeline depth,
// 3x3 window indexing and the delayed image sideband flags.
package jelly_img_sobel_grad_pkg;

  localparam int unsigned SOBEL_LATENCY = 3;
  localparam int unsigned WIN_DIM       = 3;

  typedef struct packed {
    logic line_first;
    logic line_last;
    logic pixel_first;
    logic pixel_last;
    logic de;
    logic valid;
  } img_flags_t;

  // Pixel (y,x) occupies slot y*3+x of the flattened window.
  function automatic int unsigned win_idx(input int unsigned y, input int unsigned x);
    return y * WIN_DIM + x;
  endfunction

endpackage

// File: rtl/jelly_img_sobel_grad_calc.sv
// Three-stage Sobel datapath: weighted row/column sums, signed gradients with
// magnitudes, then clamped gradients and saturated L1 edge strength.
module jelly_img_sobel_grad_calc
  import jelly_img_sobel_grad_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned GRAD_WIDTH = DATA_WIDTH + 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cke_i,
  input  logic [9*DATA_WIDTH-1:0]       win_i,
  output logic signed [GRAD_WIDTH-1:0]  gx_o,
  output logic signed [GRAD_WIDTH-1:0]  gy_o,
  output logic [DATA_WIDTH-1:0]         mag_o
);

  localparam int unsigned SUM_W  = DATA_WIDTH + 2;
  localparam int unsigned DIFF_W = DATA_WIDTH + 3;
  localparam int unsigned MAG_W  = DATA_WIDTH + 4;
  localparam int          GRAD_MAX = int'((1 << (GRAD_WIDTH - 1)) - 1);
  localparam int          GRAD_MIN = -GRAD_MAX - 1;

  // Narrow outputs clamp to the representable range; wide outputs sign-extend.
  function automatic logic signed [GRAD_WIDTH-1:0] clamp(input logic signed [DIFF_W-1:0] v);
    if (GRAD_WIDTH >= DIFF_W)   return GRAD_WIDTH'(v);
    else if (int'(v) > GRAD_MAX) return GRAD_WIDTH'(GRAD_MAX);
    else if (int'(v) < GRAD_MIN) return GRAD_WIDTH'(GRAD_MIN);
    else                         return GRAD_WIDTH'(v);
  endfunction

  logic [DATA_WIDTH-1:0] pix [WIN_DIM][WIN_DIM];

  logic [SUM_W-1:0]              l_d, r_d, t_d, b_d;
  logic [SUM_W-1:0]              l_q, r_q, t_q, b_q;
  logic signed [DIFF_W-1:0]      gx_d, gy_d, gx_q, gy_q;
  logic [SUM_W-1:0]              ax_d, ay_d, ax_q, ay_q;
  logic [MAG_W-1:0]              sum;
  logic signed [GRAD_WIDTH-1:0]  gx_out_d, gy_out_d, gx_out_q, gy_out_q;
  logic [DATA_WIDTH-1:0]         mag_d, mag_q;

  always_comb begin
    for (int unsigned y = 0; y < WIN_DIM; y++) begin
      for (int unsigned x = 0; x < WIN_DIM; x++) begin
        pix[y][x] = win_i[win_idx(y, x)*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    l_d = SUM_W'(pix[0][0]) + (SUM_W'(pix[1][0]) << 1) + SUM_W'(pix[2][0]);
    r_d = SUM_W'(pix[0][2]) + (SUM_W'(pix[1][2]) << 1) + SUM_W'(pix[2][2]);
    t_d = SUM_W'(pix[0][0]) + (SUM_W'(pix[0][1]) << 1) + SUM_W'(pix[0][2]);
    b_d = SUM_W'(pix[2][0]) + (SUM_W'(pix[2][1]) << 1) + SUM_W'(pix[2][2]);

    gx_d = $signed({1'b0, r_q}) - $signed({1'b0, l_q});
    gy_d = $signed({1'b0, b_q}) - $signed({1'b0, t_q});
    ax_d = gx_d[DIFF_W-1] ? SUM_W'(-gx_d) : SUM_W'(gx_d);
    ay_d = gy_d[DIFF_W-1] ? SUM_W'(-gy_d) : SUM_W'(gy_d);

    sum      = MAG_W'(ax_q) + MAG_W'(ay_q);
    mag_d    = (|sum[MAG_W-1:DATA_WIDTH]) ? '1 : DATA_WIDTH'(sum);
    gx_out_d = clamp(gx_q);
    gy_out_d = clamp(gy_q);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      l_q      <= '0;
      r_q      <= '0;
      t_q      <= '0;
      b_q      <= '0;
      gx_q     <= '0;
      gy_q     <= '0;
      ax_q     <= '0;
      ay_q     <= '0;
      gx_out_q <= '0;
      gy_out_q <= '0;
      mag_q    <= '0;
    end else if (cke_i) begin
      l_q      <= l_d;
      r_q      <= r_d;
      t_q      <= t_d;
      b_q      <= b_d;
      gx_q     <= gx_d;
      gy_q     <= gy_d;
      ax_q     <= ax_d;
      ay_q     <= ay_d;
      gx_out_q <= gx_out_d;
      gy_out_q <= gy_out_d;
      mag_q    <= mag_d;
    end
  end

  assign gx_o  = gx_out_q;
  assign gy_o  = gy_out_q;
  assign mag_o = mag_q;

endmodule

// File: rtl/jelly_img_sobel_grad.sv
// Sobel gradient stage for a 3x3 image window; sideband and user bits ride a
// delay line matched to the arithmetic pipeline.
module jelly_img_sobel_grad
  import jelly_img_sobel_grad_pkg::*;
#(
  parameter int unsigned USER_WIDTH = 0,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned GRAD_WIDTH = DATA_WIDTH + 3,
  localparam int unsigned USER_BITS = (USER_WIDTH > 0) ? USER_WIDTH : 1
) (
  input  logic                          reset,
  input  logic                          clk,
  input  logic                          cke,

  input  logic                          s_img_line_first,
  input  logic                          s_img_line_last,
  input  logic                          s_img_pixel_first,
  input  logic                          s_img_pixel_last,
  input  logic                          s_img_de,
  input  logic [USER_BITS-1:0]          s_img_user,
  input  logic [9*DATA_WIDTH-1:0]       s_img_data,
  input  logic                          s_img_valid,

  output logic                          m_img_line_first,
  output logic                          m_img_line_last,
  output logic                          m_img_pixel_first,
  output logic                          m_img_pixel_last,
  output logic                          m_img_de,
  output logic [USER_BITS-1:0]          m_img_user,
  output logic signed [GRAD_WIDTH-1:0]  m_img_grad_x,
  output logic signed [GRAD_WIDTH-1:0]  m_img_grad_y,
  output logic [DATA_WIDTH-1:0]         m_img_mag,
  output logic                          m_img_valid
);

  img_flags_t           flags_d;
  logic [USER_BITS-1:0] user_d;
  img_flags_t           flags_q [SOBEL_LATENCY];
  logic [USER_BITS-1:0] user_q  [SOBEL_LATENCY];

  always_comb begin
    flags_d.line_first  = s_img_line_first;
    flags_d.line_last   = s_img_line_last;
    flags_d.pixel_first = s_img_pixel_first;
    flags_d.pixel_last  = s_img_pixel_last;
    flags_d.de          = s_img_de;
    flags_d.valid       = s_img_valid;
    user_d              = (USER_WIDTH > 0) ? s_img_user : '0;
  end

  // Sideband delay line, same depth and enable as the datapath.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < SOBEL_LATENCY; i++) begin
        flags_q[i] <= '0;
        user_q[i]  <= '0;
      end
    end else if (cke) begin
      flags_q[0] <= flags_d;
      user_q[0]  <= user_d;
      for (int unsigned i = 1; i < SOBEL_LATENCY; i++) begin
        flags_q[i] <= flags_q[i-1];
        user_q[i]  <= user_q[i-1];
      end
    end
  end

  jelly_img_sobel_grad_calc #(
    .DATA_WIDTH (DATA_WIDTH),
    .GRAD_WIDTH (GRAD_WIDTH)
  ) u_calc (
    .clk   (clk),
    .reset (reset),
    .cke_i (cke),
    .win_i (s_img_data),
    .gx_o  (m_img_grad_x),
    .gy_o  (m_img_grad_y),
    .mag_o (m_img_mag)
  );

  assign m_img_line_first  = flags_q[SOBEL_LATENCY-1].line_first;
  assign m_img_line_last   = flags_q[SOBEL_LATENCY-1].line_last;
  assign m_img_pixel_first = flags_q[SOBEL_LATENCY-1].pixel_first;
  assign m_img_pixel_last  = flags_q[SOBEL_LATENCY-1].pixel_last;
  assign m_img_de          = flags_q[SOBEL_LATENCY-1].de;
  assign m_img_valid       = flags_q[SOBEL_LATENCY-1].valid;
  assign m_img_user        = user_q[SOBEL_LATENCY-1];

endmodule

// File: doc/jelly_img_sobel_grad.md
Name: jelly_img_sobel_grad

Overview:
- Downstream consumer of the 3x3 window produced by jelly_img_blk_buffer (LINE_NUM=3, PIXEL_NUM=3).
- Computes the Sobel horizontal and vertical gradients and a saturated L1 magnitude in a 3-stage cke-gated pipeline.
- Carries the img sideband (first/last/de/user/valid) delay-matched to the data.
- Outputs feed the img sink path: grad_x, grad_y, edge-strength channels.

Parameters:
- USER_WIDTH, 0, width of the user sideband; 0 means no user port logic (ports kept 1 bit wide, ignored).
- DATA_WIDTH, 8, unsigned pixel width.
- GRAD_WIDTH, DATA_WIDTH+3, signed gradient output width; values outside range saturate.

Ports:
- reset  in  1  synchronous, active-low
- clk  in  1  clock
- cke  in  1  clock enable; all state holds when 0
- s_img_line_first / s_img_line_last / s_img_pixel_first / s_img_pixel_last / s_img_de  in  1 each  window sideband
- s_img_user  in  max(USER_WIDTH,1)  user sideband
- s_img_data  in  9*DATA_WIDTH  window; pixel (y,x) at [(y*3+x)*DATA_WIDTH +: DATA_WIDTH]; y=0 top row, x=0 left column, centre = (1,1)
- s_img_valid  in  1  beat valid
- m_img_line_first / m_img_line_last / m_img_pixel_first / m_img_pixel_last / m_img_de  out  1 each  delayed sideband
- m_img_user  out  max(USER_WIDTH,1)  delayed user
- m_img_grad_x  out  GRAD_WIDTH  signed, right minus left
- m_img_grad_y  out  GRAD_WIDTH  signed, bottom minus top
- m_img_mag  out  DATA_WIDTH  min(|gx|+|gy|, 2^DATA_WIDTH-1)
- m_img_valid  out  1  delayed valid

Behaviour:
- Reset: reset=0 at a clk edge clears all pipeline registers, independent of cke. All m_img_* flags, valid, grad and mag outputs read 0 the cycle after. Reset asserted mid-frame discards in-flight beats; no partial-beat recovery.
- Advance: registers update only on clk edges with cke=1 and reset=1. Latency is exactly 3 cke-qualified edges. No backpressure; the block never stalls the source.
- Stage 1: column sums L=p00+2p10+p20, R=p02+2p12+p22; row sums T=p00+2p01+p02, B=p20+2p21+p22. Each unsigned DATA_WIDTH+2 bits.
- Stage 2: gx=R-L, gy=B-T, signed DATA_WIDTH+3 bits, no loss. Output registers clamp each to [-2^(GRAD_WIDTH-1), 2^(GRAD_WIDTH-1)-1] when GRAD_WIDTH < DATA_WIDTH+3, otherwise sign-extend. The stage also computes |gx|, |gy| from the unclamped values.
- Stage 3: mag = |gx|+|gy| from the unclamped values (DATA_WIDTH+4 bits), saturated to 2^DATA_WIDTH-1. Clamped gx/gy are registered alongside it.
- Sideband, user and valid pass through a 3-deep shift register in lockstep with the data.
- Data path computes every cycle regardless of valid/de. Outputs carry defined data only while m_img_valid=1 and m_img_de=1; other beats are don't-care to consumers, but must be deterministic, with no X after reset.
- No state machine; behaviour is purely pipelined. Simultaneous reset=0 and cke=0: reset wins.

Decomposition:
- Shared package/header: SOBEL_LATENCY=3 and the window index constant (pixel (y,x) → (y*3+x)).
- One natural sub-module: jelly_img_sobel_grad_calc. It is the 3-stage arithmetic datapath (inputs: window and cke; outputs: gx, gy, mag).
- The top holds the sideband delay line and the reset/cke handling.

Test Plan:
- Flat window, all pixels 100, valid=de=1 -> 3 cke edges later grad_x=0, grad_y=0, mag=0, valid=1.
- Vertical edge: left column 0, right column 255, middle 50 -> grad_x=+1020, grad_y=0, mag=255 (saturated). Mirror the window -> grad_x=-1020.
- Horizontal edge: top row 0, middle 5, bottom row 10 -> grad_y=+40, grad_x=0, mag=40.
- Stream with pixel_first/line_first markers on beat 0 and cke held low 5 cycles mid-stream -> outputs frozen during the stall; markers emerge on the 3rd cke-qualified edge; beat order preserved.
- GRAD_WIDTH=8, vertical-edge window -> grad_x=+127; mirrored -> -128; mag still 255.
- reset=0 for one edge mid-frame with valid beats in flight -> next cycle all m_img flags, valid, grad and mag = 0; the first new beat appears exactly 3 cke edges after it is applied.
